// File: rtl/bus_initiator_if.sv
// IO_bus register-bus signal bundle between the initiator and its responders.
interface bus_initiator_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] reg_address;
  logic [31:0]           data_out;
  logic [31:0]           data_in;
  logic                  RW;
  logic                  handshake_1;
  logic                  handshake_2;

  modport master (
    output reg_address, data_out, RW, handshake_1,
    input  data_in, handshake_2
  );

  modport slave (
    input  reg_address, data_out, RW, handshake_1,
    output data_in, handshake_2
  );
endinterface

// File: rtl/bus_initiator.sv
// IO_bus initiator: runs a data phase and a status phase of four-way handshaking per host command.
// Optional txn_count/timeout_count outputs are enabled with `define BUS_INITIATOR_STATS_EN.
module bus_initiator #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_RW,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [31:0]           cmd_data,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [31:0]           rsp_status,
  output logic                  rsp_timeout,
`ifdef BUS_INITIATOR_STATS_EN
  output logic [15:0]           txn_count,
  output logic [15:0]           timeout_count,
`endif
  bus_initiator_if.master       bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK1 = 3'd2;
  localparam logic [2:0] S_WAIT_REL1 = 3'd3;
  localparam logic [2:0] S_WAIT_ACK2 = 3'd4;
  localparam logic [2:0] S_WAIT_REL2 = 3'd5;
  localparam logic [2:0] S_RESPOND   = 3'd6;

  localparam int            TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  hs1_q, hs1_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           dout_q, dout_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [31:0]           rsp_status_q, rsp_status_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  expired;
  logic                  in_wait;

  assign cmd_ready = (state_q == S_IDLE) && !bus.handshake_2;
  assign expired   = (timer_q == T_LAST);
  assign in_wait   = (state_q == S_WAIT_ACK1) || (state_q == S_WAIT_REL1) ||
                     (state_q == S_WAIT_ACK2) || (state_q == S_WAIT_REL2);

  always_comb begin
    state_d       = state_q;
    hs1_d         = hs1_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    dout_d        = dout_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_address;
          rw_d    = cmd_RW;
          dout_d  = cmd_RW ? cmd_data : 32'h0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        hs1_d   = 1'b1;
        state_d = S_WAIT_ACK1;
      end
      S_WAIT_ACK1: begin
        if (bus.handshake_2) begin
          rsp_data_d = rw_q ? 32'h0 : bus.data_in;
          hs1_d      = 1'b0;
          state_d    = S_WAIT_REL1;
        end
      end
      S_WAIT_REL1: begin
        if (!bus.handshake_2) begin
          hs1_d   = 1'b1;
          state_d = S_WAIT_ACK2;
        end
      end
      S_WAIT_ACK2: begin
        if (bus.handshake_2) begin
          rsp_status_d = bus.data_in;
          hs1_d        = 1'b0;
          state_d      = S_WAIT_REL2;
        end
      end
      S_WAIT_REL2: begin
        if (!bus.handshake_2) begin
          rsp_timeout_d = 1'b0;
          state_d       = S_RESPOND;
        end
      end
      S_RESPOND: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort only when the awaited edge has not arrived; a same-cycle arrival already moved state_d.
    if (in_wait && expired && (state_d == state_q)) begin
      hs1_d         = 1'b0;
      rsp_data_d    = 32'hFFFF_FFFF;
      rsp_status_d  = 32'h0;
      rsp_timeout_d = 1'b1;
      state_d       = S_RESPOND;
    end
    if (state_d != state_q) timer_d = '0;
    else if (in_wait)       timer_d = timer_q + TW'(1);
    else                    timer_d = timer_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      hs1_q         <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
      rsp_status_q  <= 32'h0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      hs1_q         <= hs1_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      dout_q        <= dout_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.handshake_1 = hs1_q;
  assign bus.RW          = rw_q;
  assign bus.reg_address = addr_q;
  assign bus.data_out    = dout_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_status      = rsp_status_q;
  assign rsp_timeout     = rsp_timeout_q;

`ifdef BUS_INITIATOR_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;
  logic [15:0] timeout_count_q, timeout_count_d;

  always_comb begin
    txn_count_d     = txn_count_q;
    timeout_count_d = timeout_count_q;
    if (state_q == S_RESPOND) begin
      txn_count_d = txn_count_q + 16'd1;
      if (rsp_timeout_q) timeout_count_d = timeout_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_count_q     <= 16'h0;
      timeout_count_q <= 16'h0;
    end else begin
      txn_count_q     <= txn_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign txn_count     = txn_count_q;
  assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Randomized bench for bus_initiator with a configurable responder and a transaction-level model.
module tb_bus_initiator;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_RW = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [31:0]   cmd_data = '0;
  logic          cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0]   rsp_data, rsp_status;
`ifdef BUS_INITIATOR_STATS_EN
  logic [15:0]   txn_count, timeout_count;
`endif

  always #5 clk = ~clk;

  bus_initiator_if #(.ADDR_WIDTH(AW)) bif ();

  bus_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_RW(cmd_RW),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rsp_timeout(rsp_timeout),
`ifdef BUS_INITIATOR_STATS_EN
    .txn_count(txn_count), .timeout_count(timeout_count),
`endif
    .bus(bif.master)
  );

  // Responder: mode 0 acks combinationally, mode 1 acks/releases after per-phase delays, mode 2 is absent.
  int            mode = 0;
  int            dly [4] = '{0, 0, 0, 0};
  logic [31:0]   dword = '0, sword = '0;
  logic          stuck = 1'b0;
  logic          hs2r = 1'b0;
  int            cnt = 0;
  logic          ph = 1'b0;
  logic          hs1_prev = 1'b0;
  int            hs1_cycles = 0;
  logic          bad_bus = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic          e_rw = 1'b0;
  logic [31:0]   e_dout = '0;

  int n_vec = 0, n_err = 0;
  int m_txn = 0, m_to = 0;

  assign bif.handshake_2 = stuck || ((mode == 0) ? bif.handshake_1 : ((mode == 1) && hs2r));
  assign bif.data_in     = ph ? sword : dword;

  always @(posedge clk) begin
    hs1_prev <= bif.handshake_1;
    if (bif.handshake_1) hs1_cycles <= hs1_cycles + 1;
    if ((bif.handshake_1 || bif.handshake_2) &&
        (bif.reg_address !== e_addr || bif.RW !== e_rw || bif.data_out !== e_dout))
      bad_bus <= 1'b1;
    if (cmd_valid && cmd_ready) begin
      ph <= 1'b0; cnt <= 0; hs2r <= 1'b0; hs1_cycles <= 0; bad_bus <= 1'b0;
    end else if (mode != 1) begin
      hs2r <= 1'b0; cnt <= 0;
      if (mode == 0 && hs1_prev && !bif.handshake_1) ph <= ~ph;
    end else if (bif.handshake_1 && !hs2r) begin
      if (cnt >= dly[ph ? 2 : 0]) begin hs2r <= 1'b1; cnt <= 0; end
      else cnt <= cnt + 1;
    end else if (!bif.handshake_1 && hs2r) begin
      if (cnt >= dly[ph ? 3 : 1]) begin hs2r <= 1'b0; cnt <= 0; ph <= ~ph; end
      else cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic check_stats();
`ifdef BUS_INITIATOR_STATS_EN
    chk("txn_count", {16'b0, txn_count}, m_txn & 32'hFFFF);
    chk("timeout_count", {16'b0, timeout_count}, m_to & 32'hFFFF);
`endif
  endtask

  task automatic start_cmd(input logic rw, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [31:0] dw, input logic [31:0] sw, input int md,
                           input int d0, input int d1, input int d2, input int d3);
    @(negedge clk);
    wait_ready();
    mode = md; dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    dword = dw; sword = sw;
    e_addr = a; e_rw = rw; e_dout = rw ? d : 32'h0;
    cmd_RW = rw; cmd_address = a; cmd_data = d; cmd_valid = 1'b1;
  endtask

  task automatic run_txn(input logic rw, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] dw, input logic [31:0] sw, input int md,
                         input int d0, input int d1, input int d2, input int d3,
                         input bit stk, input bit lat);
    logic        to;
    logic [31:0] xd, xs;
    int          n;
    logic        blocked;
    start_cmd(rw, a, d, dw, sw, md, d0, d1, d2, d3);
    if (stk) begin
      stuck = 1'b1;
      blocked = 1'b1;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (cmd_ready) blocked = 1'b0;
        @(negedge clk);
      end
      chk("stuck_ready_low", {31'b0, blocked}, 32'd1);
      stuck = 1'b0;
      #1;
      chk("ready_after_release", {31'b0, cmd_ready}, 32'd1);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (md == 2) to = 1'b1;
    else if (md == 1) to = (d0 > TO - 2) || (d1 > TO - 2) || (d2 > TO - 2) || (d3 > TO - 2);
    else to = 1'b0;
    xd = to ? 32'hFFFF_FFFF : (rw ? 32'h0 : dw);
    xs = to ? 32'h0 : sw;
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    if (lat) chk("latency", n, 32'd7);
    chk("rsp_data", rsp_data, xd);
    chk("rsp_status", rsp_status, xs);
    chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, to});
    chk("bus_stable", {31'b0, bad_bus}, 32'd0);
    if (md == 2) chk("hs1_high_cycles", hs1_cycles, TO);
    m_txn++;
    if (to) m_to++;
    @(posedge clk);
    #1 chk("rsp_pulse_width", {31'b0, rsp_valid}, 32'd0);
  endtask

  function automatic int rnd_dly();
    if ($urandom_range(0, 7) == 0) return $urandom_range(13, 16);
    return $urandom_range(0, 4);
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_hs1"}, {31'b0, bif.handshake_1}, 32'd0);
    chk({tag, "_rw"}, {31'b0, bif.RW}, 32'd0);
    chk({tag, "_addr"}, {24'b0, bif.reg_address}, 32'd0);
    chk({tag, "_dout"}, bif.data_out, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_status"}, rsp_status, 32'd0);
    chk({tag, "_rsp_timeout"}, {31'b0, rsp_timeout}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    check_stats();
    reset_n = 1'b1;

    run_txn(1'b1, 8'h21, 32'h0000_1234, 32'hAAAA_5555, 32'h0000_0005, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1'b0, 8'h20, 32'h0, 32'hDEAD_BEEF, 32'h0000_003F, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1'b0, 8'h33, 32'h0, 32'h1111_2222, 32'h7, 2, 0, 0, 0, 0, 0, 0);
    run_txn(1'b1, 8'h34, 32'hCAFE_0001, 32'h0, 32'h9, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1'b0, 8'h35, 32'h0, 32'h0BAD_F00D, 32'h12, 0, 0, 0, 0, 0, 1, 1);
    run_txn(1'b0, 8'h36, 32'h0, 32'h5A5A_A5A5, 32'h44, 1, 5, 3, 5, 3, 0, 0);
    run_txn(1'b1, 8'h37, 32'h8765_4321, 32'h0, 32'h55, 1, 5, 3, 5, 3, 0, 0);
    run_txn(1'b0, 8'h38, 32'h0, 32'h1357_9BDF, 32'h66, 1, TO - 2, TO - 2, TO - 2, TO - 2, 0, 0);
    run_txn(1'b0, 8'h39, 32'h0, 32'h2468_ACE0, 32'h77, 1, 0, 0, 0, TO - 1, 0, 0);
    run_txn(1'b1, 8'h3A, 32'hFEED_BEEF, 32'h0, 32'h88, 1, 1, TO - 1, 1, 1, 0, 0);
    check_stats();

    for (int i = 0; i < 40; i++) begin
      int md;
      md = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 0 : 1);
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom, $urandom,
              md, rnd_dly(), rnd_dly(), rnd_dly(), rnd_dly(), 0, 0);
    end
    check_stats();

    // Reset while waiting for the status-phase acknowledge.
    start_cmd(1'b1, 8'h5C, 32'h0F0F_F0F0, 32'h0, 32'h99, 1, 5, 3, 5, 3);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (!(ph && bif.handshake_1 && !bif.handshake_2) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reached_wait_ack2", {31'b0, bif.handshake_1}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midrst");
    m_txn = 0;
    m_to = 0;
    check_stats();
    @(negedge clk);
    reset_n = 1'b1;

    run_txn(1'b1, 8'h40, 32'h1, 32'h0, 32'hA1, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1'b0, 8'h41, 32'h0, 32'hB2B2_B2B2, 32'hA2, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1'b0, 8'h42, 32'h0, 32'hC3C3_C3C3, 32'hA3, 0, 0, 0, 0, 0, 0, 1);
    run_txn(1'b0, 8'h43, 32'h0, 32'hD4D4_D4D4, 32'hA4, 2, 0, 0, 0, 0, 0, 0);
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Initiator end of the internal 32-bit register bus (IO_bus). Subsystem channels such as QE and PWM are responders on this bus, each using its own bus_FSM.
- Takes single register commands from the host-side interface (uP/SPI bridge) and runs the two-phase four-way handshake: a data phase, then a status phase.
- Returns read data, responder status and a timeout flag to the host side.

Parameters:
- ADDR_WIDTH, 8, width of reg_address.
- TIMEOUT_CYCLES, 1024, clk cycles allowed in any wait state before abort; minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- cmd_valid  input  1  host command request
- cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready
- cmd_RW  input  1  1 = write register (bus data_out to responder), 0 = read
- cmd_address  input  ADDR_WIDTH  target register number
- cmd_data  input  32  write data
- rsp_valid  output  1  one-cycle pulse, response fields valid
- rsp_data  output  32  read data (0 for writes)
- rsp_status  output  32  status word returned in the status phase
- rsp_timeout  output  1  transaction aborted by timeout
- reg_address  output  ADDR_WIDTH  bus register address
- data_out  output  32  bus write data
- data_in  input  32  bus read data (tri-stated by responders)
- RW  output  1  bus direction
- handshake_1  output  1  initiator strobe
- handshake_2  input  1  responder acknowledge (same clock domain, no synchroniser)

Behaviour:
- Reset values: state IDLE, handshake_1=0, RW=0, reg_address=0, data_out=0, rsp_valid=0, rsp_data=0, rsp_status=0, rsp_timeout=0, timer=0.
- All outputs are registered.
- cmd_ready = (state==IDLE) && !handshake_2. Commands are never accepted while a stale acknowledge is still high.
- States and transitions:
  - IDLE: on accept, latch cmd_address→reg_address, cmd_RW→RW, data_out=cmd_RW ? cmd_data : 0. Go to SETUP.
  - SETUP: one cycle for address/data setup. Set handshake_1=1. Go to WAIT_ACK1.
  - WAIT_ACK1: on handshake_2==1, if RW==0 capture data_in→rsp_data, else rsp_data=0. Clear handshake_1. Go to WAIT_REL1.
  - WAIT_REL1: on handshake_2==0, set handshake_1=1. Go to WAIT_ACK2.
  - WAIT_ACK2: on handshake_2==1, capture data_in→rsp_status. Clear handshake_1. Go to WAIT_REL2.
  - WAIT_REL2: on handshake_2==0, go to RESPOND.
  - RESPOND: rsp_valid=1 for exactly one cycle, rsp_timeout=0. Go to IDLE.
- Timer:
  - Cleared on every state change.
  - Increments each cycle spent in a WAIT_* state.
  - When timer reaches TIMEOUT_CYCLES-1 with the awaited condition still false: handshake_1=0, rsp_data=32'hFFFF_FFFF, rsp_status=0, rsp_timeout=1, go to RESPOND. RESPOND keeps rsp_timeout=1 in this case.
  - If the condition becomes true in the same cycle the timer expires, the condition wins.
- reg_address, RW and data_out hold from the accept cycle until the next accept. They never change while handshake_1 or handshake_2 is high.
- Latency with a responder that acks and releases in the next cycle: accept → rsp_valid = 7 cycles.
- rsp_data, rsp_status and rsp_timeout hold their values until the next RESPOND.
- Reset mid-transaction: immediate return to reset values. A responder left holding handshake_2 high blocks cmd_ready until it releases.
- cmd_valid while busy is ignored and must be held by the host.

Optional Feature:
- Macro: BUS_INITIATOR_STATS_EN.
- Defined: adds output ports txn_count[15:0] and timeout_count[15:0], both reset to 0.
  - txn_count increments on every RESPOND.
  - timeout_count increments on RESPOND with rsp_timeout=1.
  - Both wrap 16'hFFFF→0.
- Not defined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Write: cmd_RW=1, address 8'h21, data 32'h0000_1234, zero-wait responder model → bus shows RW=1, reg_address=8'h21, data_out=32'h1234 while handshake_1 is high. rsp_valid fires 7 cycles after accept. rsp_data=0, rsp_timeout=0, rsp_status equals the model's status 32'h0000_0005.
- Read: cmd_RW=0, address 8'h20, model returns 32'hDEAD_BEEF in data phase and 32'h3F in status phase → rsp_data=32'hDEADBEEF, rsp_status=32'h3F.
- Timeout: no responder (handshake_2 stuck 0), TIMEOUT_CYCLES=16 → handshake_1 drops after 16 cycles in WAIT_ACK1. rsp_valid with rsp_timeout=1, rsp_data=32'hFFFFFFFF. Next command is accepted normally.
- Stuck acknowledge: handshake_2 held 1 from IDLE for 20 cycles → cmd_ready=0 throughout; command accepted the cycle after handshake_2 falls.
- Slow responder: ack delayed 5 cycles and release delayed 3 cycles in each phase → correct data. Address and data stable throughout; no timeout.
- Reset asserted in WAIT_ACK2 → all outputs return to reset values immediately. With BUS_INITIATOR_STATS_EN defined, 3 good transactions plus 1 timeout → txn_count=4, timeout_count=1.
